// File: rtl/sram_access_initiator.sv
// Initiator side of a single-port, byte-enabled SRAM: sized load/store requests in, one response out.
// Define SRAM_ACCESS_INITIATOR_CLEAR_EN to zero the whole SRAM after every reset.
module sram_access_initiator #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  sram_clock,
  input  logic                  sram_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_error,
  output logic                  init_busy,
  output logic                  sram_read,
  output logic                  sram_write,
  output logic [3:0]            sram_byte_enables,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [31:0]           sram_write_data,
  input  logic [31:0]           sram_read_data
);

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESPOND, CLEAR} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

`ifdef SRAM_ACCESS_INITIATOR_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t                  state_q, state_d;
  logic                    op_write_q;
  logic                    op_signed_q;
  logic [1:0]              op_size_q;
  logic [1:0]              op_lane_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              be_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rsp_data_q;
  logic                    rsp_error_q;

  logic                    req_illegal;
  logic [3:0]              be_calc;
  logic [31:0]             wdata_calc;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [31:0]             rd_ext;

`ifdef SRAM_ACCESS_INITIATOR_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   clear_cnt_q;
  assign init_busy = (state_q == CLEAR);
`else
  assign init_busy = 1'b0;
`endif

  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

  // Request decode: legality, byte enables and lane-replicated write data.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_illegal = 1'b0;
    be_calc     = 4'hF;
    wdata_calc  = req_write_data;
    case (req_size)
      SIZE_BYTE: begin
        be_calc    = 4'b0001 << req_address[1:0];
        wdata_calc = {4{req_write_data[7:0]}};
      end
      SIZE_HALF: begin
        req_illegal = req_address[0];
        be_calc     = req_address[1] ? 4'b1100 : 4'b0011;
        wdata_calc  = {2{req_write_data[15:0]}};
      end
      SIZE_WORD: req_illegal = (req_address[1:0] != 2'b00);
      default:   req_illegal = 1'b1;
    endcase
  end

  // Read lane extraction and sign/zero extension of the word returned by the SRAM.
  always_comb begin
    lane_byte = sram_read_data[7:0];
    case (op_lane_q)
      2'd1:    lane_byte = sram_read_data[15:8];
      2'd2:    lane_byte = sram_read_data[23:16];
      2'd3:    lane_byte = sram_read_data[31:24];
      default: lane_byte = sram_read_data[7:0];
    endcase
    lane_half = op_lane_q[1] ? sram_read_data[31:16] : sram_read_data[15:0];
    case (op_size_q)
      SIZE_BYTE: rd_ext = {{24{op_signed_q & lane_byte[7]}}, lane_byte};
      SIZE_HALF: rd_ext = {{16{op_signed_q & lane_half[15]}}, lane_half};
      default:   rd_ext = sram_read_data;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    req_ready         = 1'b0;
    rsp_valid         = 1'b0;
    sram_read         = 1'b0;
    sram_write        = 1'b0;
    sram_address      = addr_q;
    sram_byte_enables = be_q;
    sram_write_data   = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_illegal ? RESPOND : ACCESS;
      end
      ACCESS: begin
        sram_read  = ~op_write_q;
        sram_write = op_write_q;
        state_d    = CAPTURE;
      end
      CAPTURE: state_d = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
`ifdef SRAM_ACCESS_INITIATOR_CLEAR_EN
      CLEAR: begin
        sram_write        = 1'b1;
        sram_address      = clear_cnt_q;
        sram_byte_enables = 4'hF;
        sram_write_data   = '0;
        if (clear_cnt_q == '1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_q     <= RESET_STATE;
      op_write_q  <= 1'b0;
      op_signed_q <= 1'b0;
      op_size_q   <= 2'b00;
      op_lane_q   <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'h0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
`ifdef SRAM_ACCESS_INITIATOR_CLEAR_EN
      clear_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        rsp_error_q <= req_illegal;
        rsp_data_q  <= '0;
        if (!req_illegal) begin
          op_write_q  <= req_write;
          op_signed_q <= req_signed;
          op_size_q   <= req_size;
          op_lane_q   <= req_address[1:0];
          addr_q      <= req_address[ADDR_WIDTH+1:2];
          be_q        <= be_calc;
          wdata_q     <= wdata_calc;
        end
      end
      if (state_q == CAPTURE) rsp_data_q <= op_write_q ? '0 : rd_ext;
`ifdef SRAM_ACCESS_INITIATOR_CLEAR_EN
      if (state_q == CLEAR) clear_cnt_q <= clear_cnt_q + 1'b1;
`endif
    end
  end

endmodule
